led_counter_renderer: RTL
=========================

Name: led_counter_renderer

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 32x32 RGB565 LED sprite ROMs (rom_led_on / rom_led_off, 1024x16, 1-cycle registered read).
- Maintains an N-bit frame-paced binary counter and draws it as a horizontal row of LED sprites: lit LED for a 1 bit, dark LED for a 0 bit.
- Drives the shared ROM address, consumes both ROM outputs, applies transparency, and emits RGB565 with delay-matched hsync/vsync/de to the VGA output stage.

Parameters:
- N_LEDS, 8, number of LEDs/counter bits (1..16); MSB is drawn leftmost.
- X0, 10'd64, left pixel column of the LED row.
- Y0, 10'd224, top pixel row of the LED row.
- FRAMES_PER_STEP, 30, frames per counter increment (>=1).
- BG_COLOR, 16'h0000, RGB565 colour used for transparent pixels and the non-sprite active area.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- x  in  10  current pixel column from the timing generator.
- y  in  10  current pixel row from the timing generator.
- de_in  in  1  active-video flag aligned with x/y.
- hsync_in  in  1  horizontal sync aligned with x/y.
- vsync_in  in  1  vertical sync, active-low, aligned with x/y.
- count_en  in  1  counter advance enable.
- rom_ad  out  10  shared sprite ROM address, {row[4:0], col[4:0]}.
- rom_ce  out  1  ROM clock enable.
- rom_on_dout  in  16  lit-sprite ROM data, valid 1 cycle after rom_ad.
- rom_off_dout  in  16  dark-sprite ROM data, valid 1 cycle after rom_ad.
- rgb  out  16  RGB565 pixel.
- de_out  out  1  delayed de_in.
- hsync_out  out  1  delayed hsync_in.
- vsync_out  out  1  delayed vsync_in.
- count  out  N_LEDS  displayed counter value.

Behaviour:
- Reset (async, rst_n=0): rgb=0, de_out=0, hsync_out=1, vsync_out=1, rom_ad=0, count=0, frame divider=0, displayed latch=0. Every pipeline register clears.
- rom_ce is tied to 1. ROM oce is tied to 1 and ROM reset is tied to 0 outside this block.

Pipeline, total latency 3 clocks, x/y to rgb:
- S1: dx = x - X0 in 11-bit arithmetic. Compute in_row = (y >= Y0) && (y < Y0+32), and in_led = (x >= X0) && (dx < 32*N_LEDS).
  - idx = dx[9:5], giving LED number 0 at the left.
  - Register rom_ad = {(y-Y0)[4:0], dx[4:0]}. rom_ad is don't-care when not inside the sprite area.
  - Register hit = de_in & in_row & in_led, and bitsel = shown[N_LEDS-1-idx].
- S2: ROM data valid. Carry hit and bitsel forward one more register stage alongside the data.
- S3: pix = bitsel ? rom_on_dout : rom_off_dout.
  - rgb = !de ? 0 : (hit && pix != 16'h0000) ? pix : BG_COLOR.
- de, hsync and vsync pass through an identical 3-stage shift chain so they stay aligned with rgb.

Counter:
- The frame boundary is the falling edge of vsync_in, detected with a 1-cycle registered edge detector.
- At each boundary: if count_en, the divider increments. When the divider reaches FRAMES_PER_STEP-1, it clears and count increments modulo 2^N_LEDS, so all-ones wraps to 0.
- If count_en=0 at a boundary, the divider holds.
- The displayed latch `shown` loads count on the vsync falling edge, one clock after count updates. The image therefore never changes mid-frame, which prevents tearing.
- count_en toggling mid-frame only takes effect at the next boundary.
- rst_n assert mid-frame: outputs clear immediately. After release, output resumes in blank with sync idle until new inputs propagate through the 3 stages.
- x/y values outside the sprite area never index out of range: idx is only used when hit=1.

Decomposition:
- Shared package led_pkg: SPR_W=32, SPR_H=32, SPR_AW=10, RGB565 width 16, TRANSPARENT=16'h0000.
- One sub-module, frame_step_counter: vsync edge detect, frame divider, count, shown latch.
- Pixel pipeline and mux stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-line -> rgb=0, de_out=0, hsync_out=vsync_out=1, count=0 immediately, before any clock edge.
- Address mapping: x=X0+37, y=Y0+5, de=1 -> rom_ad=10'h0A5 one clock later. rgb reflects the chosen ROM data 3 clocks after x/y.
- Bit select: shown=8'b1000_0000 with ROM models returning 16'hF800 (on) and 16'h07E0 (off) -> x in [64,95] gives F800; x in [96,319] gives 07E0; x=320 gives BG_COLOR.
- Transparency and blanking: in-sprite ROM data 16'h0000 -> rgb=BG_COLOR. de_in=0 inside the sprite area -> rgb=0. Sync chain is delayed exactly 3 clocks.
- Counter pacing: FRAMES_PER_STEP=2, count_en=1, 6 vsync falls -> count goes 0,0,1,1,2,2,3 (one value after each fall). With count_en=0 the count holds. With N_LEDS=2 it wraps 3 -> 0.
- No mid-frame change: force a count change mid-frame -> rgb is unchanged until after the next vsync falling edge.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared constants and types for the LED counter renderer.
//   SPR_W / SPR_H   : sprite size in pixels (32x32)
//   SPR_CW / SPR_RW : column / row bits of the sprite ROM address
//   SPR_AW          : sprite ROM address width ({row, col})
//   RGB_W           : RGB565 pixel width
//   TRANSPARENT     : sprite colour that lets the background show through
//   sync_t          : de/hsync/vsync bundle carried down the pixel pipeline
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int SPR_CW = $clog2(SPR_W);
  localparam int SPR_RW = $clog2(SPR_H);
  localparam int SPR_AW = SPR_RW + SPR_CW;
  localparam int RGB_W  = 16;

  localparam logic [RGB_W-1:0] TRANSPARENT = 16'h0000;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  // Blanked video with both (active-low) syncs inactive.
  localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/frame_step_counter.sv
// ---------------------------------------------------------------------------
// frame_step_counter
// Frame-paced binary counter for the LED row.
//   clk       in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   vsync_in  in   vertical sync (active-low); its falling edge marks a frame
//   count_en  in   advance enable, sampled only at the frame boundary
//   count     out  running counter value
//   shown     out  copy of count used for drawing; only changes at a frame
//                  boundary so a frame is never drawn with two values
// ---------------------------------------------------------------------------
module frame_step_counter #(
  parameter int N_LEDS          = 8,
  parameter int FRAMES_PER_STEP = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_in,
  input  logic              count_en,
  output logic [N_LEDS-1:0] count,
  output logic [N_LEDS-1:0] shown
);

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  logic             vsync_q;
  logic             frame_start;
  logic             load_shown;
  logic [DIV_W-1:0] div;

  assign frame_start = vsync_q & ~vsync_in;

  // Edge detector state, plus a one-cycle delayed strobe so that shown picks
  // up the value count has just moved to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b1;
      load_shown <= 1'b0;
    end else begin
      vsync_q    <= vsync_in;
      load_shown <= frame_start;
    end
  end

  // The divider only moves on enabled frame boundaries; count steps when the
  // divider wraps, and wraps itself modulo 2^N_LEDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      count <= '0;
    end else if (frame_start && count_en) begin
      if (div == DIV_LAST) begin
        div   <= '0;
        count <= count + N_LEDS'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown <= '0;
    end else if (load_shown) begin
      shown <= count;
    end
  end

endmodule

// File: rtl/led_counter_renderer.sv
// ---------------------------------------------------------------------------
// led_counter_renderer
// Draws an N_LEDS-bit frame-paced counter as a row of 32x32 LED sprites
// (lit sprite for a 1 bit, dark sprite for a 0 bit, MSB leftmost). Drives
// the shared sprite ROM address, picks the lit/dark ROM output, applies
// transparency and outputs RGB565 three clocks after x/y, with de/hsync/vsync
// delayed by the same amount.
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   x, y               current pixel position from the timing generator
//   de_in              active video, aligned with x/y
//   hsync_in, vsync_in syncs aligned with x/y (vsync active-low)
//   count_en           counter advance enable
//   rom_ad, rom_ce     shared sprite ROM address {row, col} and clock enable
//   rom_on_dout        lit-sprite ROM data, one clock after rom_ad
//   rom_off_dout       dark-sprite ROM data, one clock after rom_ad
//   rgb                RGB565 output pixel
//   de_out, hsync_out, vsync_out  syncs aligned with rgb
//   count              current counter value
// ---------------------------------------------------------------------------
module led_counter_renderer
  import led_pkg::*;
#(
  parameter int          N_LEDS          = 8,
  parameter logic [9:0]  X0              = 10'd64,
  parameter logic [9:0]  Y0              = 10'd224,
  parameter int          FRAMES_PER_STEP = 30,
  parameter logic [15:0] BG_COLOR        = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              count_en,
  output logic [SPR_AW-1:0] rom_ad,
  output logic              rom_ce,
  input  logic [RGB_W-1:0]  rom_on_dout,
  input  logic [RGB_W-1:0]  rom_off_dout,
  output logic [RGB_W-1:0]  rgb,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [N_LEDS-1:0] count
);

  logic [N_LEDS-1:0] shown;

  logic [10:0]      dx;
  logic [10:0]      dy;
  logic             in_row;
  logic             in_led;
  logic [4:0]       led_idx;
  logic             bitsel_c;
  sync_t            sync_in;
  sync_t [2:0]      sync_pipe;
  logic             hit1;
  logic             bitsel1;
  logic             hit2;
  logic             bitsel2;
  logic [RGB_W-1:0] pix;
  logic [RGB_W-1:0] rgb_c;

  frame_step_counter #(
    .N_LEDS          (N_LEDS),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync_in (vsync_in),
    .count_en (count_en),
    .count    (count),
    .shown    (shown)
  );

  assign rom_ce = 1'b1;

  // Offsets are taken in 11 bits so a pixel left of / above the row becomes
  // a large value and fails the upper-bound test instead of aliasing.
  assign dx      = {1'b0, x} - {1'b0, X0};
  assign dy      = {1'b0, y} - {1'b0, Y0};
  assign in_row  = (y >= Y0) && (dy < 11'(SPR_H));
  assign in_led  = (x >= X0) && (dx < 11'(SPR_W * N_LEDS));
  assign led_idx = dx[SPR_CW +: 5];

  // LED 0 sits at the left and shows the MSB. A compare-per-bit lookup keeps
  // the select in range for any led_idx; the result only matters when hit.
  always_comb begin
    bitsel_c = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (led_idx == 5'(N_LEDS - 1 - i)) begin
        bitsel_c = shown[i];
      end
    end
  end

  assign sync_in = '{de: de_in, hsync: hsync_in, vsync: vsync_in};

  // Stage 1: ROM address plus the per-pixel hit/bit decision.
  // Stage 2: ROM data arrives; hit/bit move along with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ad  <= '0;
      hit1    <= 1'b0;
      bitsel1 <= 1'b0;
      hit2    <= 1'b0;
      bitsel2 <= 1'b0;
    end else begin
      rom_ad  <= {dy[SPR_RW-1:0], dx[SPR_CW-1:0]};
      hit1    <= de_in & in_row & in_led;
      bitsel1 <= bitsel_c;
      hit2    <= hit1;
      bitsel2 <= bitsel1;
    end
  end

  // Syncs ride a three-deep chain so they leave together with rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= {3{SYNC_IDLE}};
    end else begin
      sync_pipe <= {sync_pipe[1:0], sync_in};
    end
  end

  // Blanking forces black; transparent sprite pixels and everything outside
  // the sprite row fall back to the background colour.
  always_comb begin
    pix   = bitsel2 ? rom_on_dout : rom_off_dout;
    rgb_c = BG_COLOR;
    if (!sync_pipe[1].de) begin
      rgb_c = '0;
    end else if (hit2 && (pix != TRANSPARENT)) begin
      rgb_c = pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= '0;
    end else begin
      rgb <= rgb_c;
    end
  end

  assign de_out    = sync_pipe[2].de;
  assign hsync_out = sync_pipe[2].hsync;
  assign vsync_out = sync_pipe[2].vsync;

endmodule
